any1_mem_sel_split: RTL
=======================

Name: any1_mem_sel_split

Overview:
- Parametrised successor to the combinational load/store byte-select decode, sitting between the memory stage and the data bus interface.
- Accepts one memory request of size 2^n bytes at any byte address and generates bus-width byte-lane selects.
- Splits accesses that cross a bus-word boundary into two bus cycles.
- Lane-shifts write data out and merges/right-aligns read data back into a single response.

Parameters:
- BUS_BYTES, 32, bus width in bytes (power of two, 4..64); sel_o width.
- AWID, 32, address width in bits.
- CNTW, 16, width of the saturating split-event counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request offered
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  3  log2 of access bytes (0=1B .. 6=64B)
- req_adr_i  in  AWID  byte address
- req_dat_i  in  BUS_BYTES*8  store data, right-aligned
- cyc_o  out  1  bus cycle active
- we_o  out  1  bus write
- adr_o  out  AWID  bus-word-aligned address
- sel_o  out  BUS_BYTES  byte-lane select
- dat_o  out  BUS_BYTES*8  lane-shifted store data
- ack_i  in  1  bus beat complete
- err_i  in  1  bus error (terminates beat)
- dat_i  in  BUS_BYTES*8  bus read data
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  response consumed
- resp_err_o  out  1  response is an error
- resp_dat_o  out  BUS_BYTES*8  load data, right-aligned, zero-extended
- split_cnt_o  out  CNTW  count of split requests, saturating

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; req_ready_o=1; cyc_o=0, we_o=0, adr_o=0, sel_o=0, dat_o=0; resp_valid_o=0, resp_err_o=0, resp_dat_o=0; split_cnt_o=0. Reset mid-operation drops cyc_o immediately and discards the request.
- Definitions: off = adr[log2(BUS_BYTES)-1:0]; nb = 2^size; mask2 = ((1<<nb)-1)<<off in 2*BUS_BYTES bits; selLo = mask2 low half; selHi = mask2 high half.
- States: IDLE, BEAT0, BEAT1, RESP. One transaction in flight.
- IDLE: req_ready_o=1.
  - On req_valid_i with size > log2(BUS_BYTES): go RESP with resp_err_o=1 and resp_dat_o=0. No bus cycle.
  - Otherwise latch request and go BEAT0. If selHi != 0, increment split_cnt_o (saturates at all-ones).
- BEAT0: cyc_o=1; we_o=req_we; adr_o = adr with low log2(BUS_BYTES) bits cleared; sel_o=selLo; dat_o = low half of (wdata << 8*off).
  - On ack_i: capture dat_i as low word. Go BEAT1 if selHi != 0, else RESP.
  - On err_i: go RESP with resp_err_o=1. Second beat skipped.
- BEAT1: adr_o = aligned adr + BUS_BYTES, modulo 2^AWID (wraps to 0 at top of space); sel_o=selHi; dat_o = high half of the shifted data.
  - On ack_i: capture high word and go RESP.
  - On err_i: go RESP, err.
- Bus outputs are registered. cyc_o deasserts the cycle after the final ack/err. No idle cycle is required between BEAT0 and BEAT1.
- ack_i and err_i together: err wins. ack_i/err_i outside BEAT0/BEAT1 are ignored.
- RESP: resp_valid_o=1.
  - Load: resp_dat_o = ({hi,lo} >> 8*off) masked to nb bytes, zero-extended.
  - Store: resp_dat_o = 0.
  - Outputs hold until resp_ready_i; on that cycle go IDLE.
- req_ready_o=0 outside IDLE. Minimum latency, unsplit request with immediate ack: accept at T, cyc_o at T+1, ack at T+1, resp_valid_o at T+2.
- Sel patterns for aligned accesses match the legacy decode: size1→0x3, size2→0xF, size3→0xFF, size4→0xFFFF, size5→all 32 lanes.

Test Plan:
- Load, size=2, adr=0x1004, BUS_BYTES=32 -> single beat: adr_o=0x1000, sel_o=0x000000F0. With dat_i bytes 4..7 = 0xDEADBEEF (little-endian) -> resp_dat_o=0xDEADBEEF zero-extended. split_cnt_o stays 0.
- Store, size=3, adr=0x101C, data 0x1122334455667788 -> beat0: adr_o=0x1000, sel_o=0xF0000000, bytes 28..31=0x55667788. Beat1: adr_o=0x1020, sel_o=0x0000000F, bytes 0..3=0x11223344. split_cnt_o=1.
- Request with size=6, BUS_BYTES=32 -> cyc_o never asserts; resp_valid_o with resp_err_o=1 one cycle after accept.
- Split load with err_i on beat0 -> no beat1 issued; resp_err_o=1. resp_valid_o holds while resp_ready_i=0 for 3 cycles, then clears.
- Load, size=5, adr=0xFFFFFFF0 -> beat0 adr_o=0xFFFFFFE0, sel_o=0xFFFF0000; beat1 adr_o=0x00000000, sel_o=0x0000FFFF; merged data correct.
- rst_ni pulsed low during BEAT1 -> cyc_o=0 and req_ready_o=1 asynchronously, split_cnt_o=0. A late ack_i after reset produces no response.

Source files
------------

// File: rtl/any1_mem_sel_split.sv
// any1_mem_sel_split
//   Byte-lane select generator between the memory stage and the data bus.
//   Takes one request of 2^size bytes at any byte address. It drives one or
//   two bus beats, splitting the request when it crosses a bus-word boundary.
//   It lane-shifts store data out, and merges and right-aligns load data back
//   into a single response.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_*                    request handshake (valid/ready, we, size, adr, dat)
//   cyc_o/we_o/adr_o/sel_o/dat_o  registered bus beat
//   ack_i/err_i/dat_i        bus beat termination and read data
//   resp_*                   response handshake (valid/ready, err, dat)
//   split_cnt_o              saturating count of accepted split requests
module any1_mem_sel_split #(
    parameter int BUS_BYTES = 32,
    parameter int AWID      = 32,
    parameter int CNTW      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [2:0]             req_size_i,
    input  logic [AWID-1:0]        req_adr_i,
    input  logic [BUS_BYTES*8-1:0] req_dat_i,
    output logic                   cyc_o,
    output logic                   we_o,
    output logic [AWID-1:0]        adr_o,
    output logic [BUS_BYTES-1:0]   sel_o,
    output logic [BUS_BYTES*8-1:0] dat_o,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic [BUS_BYTES*8-1:0] dat_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic                   resp_err_o,
    output logic [BUS_BYTES*8-1:0] resp_dat_o,
    output logic [CNTW-1:0]        split_cnt_o
);

    localparam int OB = $clog2(BUS_BYTES);
    localparam int DW = BUS_BYTES * 8;
    localparam logic [2*BUS_BYTES-1:0] ONES2   = '1;
    localparam logic [DW-1:0]          ONES_DW = '1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t               state;
    logic                 we_q;
    logic [OB-1:0]        off_q;
    logic [2:0]           size_q;
    logic [BUS_BYTES-1:0] sel_hi_q;
    logic [DW-1:0]        dat_hi_q;
    logic [DW-1:0]        lo_q;

    // Request decode, evaluated on the raw request inputs in IDLE
    logic                 size_ok;
    int                   nb_in;
    logic [2*BUS_BYTES-1:0] mask2;
    logic [2*DW-1:0]      wsh;
    logic [AWID-1:0]      adr_al;

    always_comb begin
        size_ok = (req_size_i <= 3'(OB));
        nb_in   = size_ok ? (1 << req_size_i) : 1;
        mask2   = (ONES2 >> (2*BUS_BYTES - nb_in)) << req_adr_i[OB-1:0];
        wsh     = {{DW{1'b0}}, req_dat_i} << (8 * req_adr_i[OB-1:0]);
        adr_al  = {req_adr_i[AWID-1:OB], {OB{1'b0}}};
    end

    // Read merge: the final beat's dat_i is combined with the captured low word
    // so the response can be registered on the same edge as the last ack.
    int              nb_q;
    logic [2*DW-1:0] rd_cat;
    logic [DW-1:0]   rmask;
    logic [DW-1:0]   merged;

    always_comb begin
        nb_q   = 1 << size_q;
        rd_cat = (state == BEAT1) ? {dat_i, lo_q} : {{DW{1'b0}}, dat_i};
        rmask  = ONES_DW >> (DW - 8*nb_q);
        merged = DW'(rd_cat >> (8 * off_q)) & rmask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            cyc_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            sel_o        <= '0;
            dat_o        <= '0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_dat_o   <= '0;
            split_cnt_o  <= '0;
            we_q         <= 1'b0;
            off_q        <= '0;
            size_q       <= '0;
            sel_hi_q     <= '0;
            dat_hi_q     <= '0;
            lo_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        if (!size_ok) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_dat_o   <= '0;
                        end else begin
                            state    <= BEAT0;
                            we_q     <= req_we_i;
                            off_q    <= req_adr_i[OB-1:0];
                            size_q   <= req_size_i;
                            sel_hi_q <= mask2[2*BUS_BYTES-1:BUS_BYTES];
                            dat_hi_q <= wsh[2*DW-1:DW];
                            cyc_o    <= 1'b1;
                            we_o     <= req_we_i;
                            adr_o    <= adr_al;
                            sel_o    <= mask2[BUS_BYTES-1:0];
                            dat_o    <= wsh[DW-1:0];
                            if (mask2[2*BUS_BYTES-1:BUS_BYTES] != '0 &&
                                split_cnt_o != '1)
                                split_cnt_o <= split_cnt_o + CNTW'(1);
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (err_i || ack_i) begin
                        if (!err_i && state == BEAT0 && sel_hi_q != '0) begin
                            // Second beat follows back-to-back; address wraps
                            // naturally at the top of the address space.
                            state <= BEAT1;
                            lo_q  <= dat_i;
                            adr_o <= adr_o + AWID'(BUS_BYTES);
                            sel_o <= sel_hi_q;
                            dat_o <= dat_hi_q;
                        end else begin
                            state        <= RESP;
                            cyc_o        <= 1'b0;
                            we_o         <= 1'b0;
                            adr_o        <= '0;
                            sel_o        <= '0;
                            dat_o        <= '0;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= err_i;
                            resp_dat_o   <= (err_i || we_q) ? '0 : merged;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_dat_o   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
